// File: rtl/localbus_arb_pkg.sv
// Shared constants for the LocalBus arbiter: FSM state codes, master indices,
// the read write-enable code and the width of the read-latency counter.
package localbus_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADDR  = 2'd1;
    localparam logic [1:0] ST_RWAIT = 2'd2;
    localparam logic [1:0] ST_RDONE = 2'd3;

    localparam logic MST_M0 = 1'b0;
    localparam logic MST_M1 = 1'b1;

    localparam logic [2:0] WE_READ = 3'b000;

    // Wide enough for any RD_LAT up to 255 cycles.
    localparam int RD_CNT_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker with an optional burst lock for master 1.
// The winner is combinational; history only advances when grant_en_i is high.
module rr_arb2 #(
    parameter int MAX_LOCK = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       lock_i,
    input  logic       grant_en_i,
    output logic       win_o
);
    import localbus_arb_pkg::*;

    logic       lastGnt_q, lastGnt_d;
    logic [7:0] lockCnt_q, lockCnt_d;
    logic       lockActive;

    assign lockActive = lock_i && (lockCnt_q < 8'(MAX_LOCK));

    always_comb begin
        win_o = MST_M0;
        if (req_i == 2'b10) begin
            win_o = MST_M1;
        end else if (req_i == 2'b11) begin
            // Under lock, M1 keeps winning ties until its budget runs out.
            if (lock_i) begin
                win_o = lockActive ? MST_M1 : MST_M0;
            end else begin
                win_o = ~lastGnt_q;
            end
        end
    end

    always_comb begin
        lastGnt_d = lastGnt_q;
        lockCnt_d = lockCnt_q;
        if (grant_en_i) begin
            lastGnt_d = win_o;
        end
        if (!lock_i) begin
            lockCnt_d = '0;
        end else if (grant_en_i) begin
            if (win_o == MST_M1) begin
                lockCnt_d = (lockCnt_q == 8'hFF) ? lockCnt_q : lockCnt_q + 8'd1;
            end else begin
                lockCnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lastGnt_q <= MST_M1;
            lockCnt_q <= '0;
        end else begin
            lastGnt_q <= lastGnt_d;
            lockCnt_q <= lockCnt_d;
        end
    end

endmodule

// File: rtl/localbus_arbiter.sv
// Shares the LocalBus between the CPU port (M0) and the DMA engine (M1),
// one transaction at a time, with registered bus drive and read-data capture.
module localbus_arbiter #(
    parameter int XLEN     = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req,
    input  logic [XLEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    input  logic [2:0]      m0_we,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [XLEN-1:0] m0_rdata,
    input  logic            m1_req,
    input  logic [XLEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    input  logic [2:0]      m1_we,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [XLEN-1:0] m1_rdata,
    input  logic            m1_lock,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_qin,
    output logic [2:0]      bus_we,
    input  logic [XLEN-1:0] bus_qout
);
    import localbus_arb_pkg::*;

    localparam logic [RD_CNT_W-1:0] LAST_WAIT = (RD_LAT > 0) ? RD_CNT_W'(RD_LAT - 1) : '0;

    logic [1:0]          state_q, state_d;
    logic                owner_q, owner_d;
    logic [XLEN-1:0]     busAddr_q, busAddr_d;
    logic [XLEN-1:0]     busQin_q, busQin_d;
    logic [2:0]          busWe_q, busWe_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          rvalid_q, rvalid_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic [RD_CNT_W-1:0] waitCnt_q, waitCnt_d;

    logic win;
    logic grantEn;

    assign grantEn = (state_q == ST_IDLE) && (m0_req || m1_req);

    rr_arb2 #(
        .MAX_LOCK (MAX_LOCK)
    ) u_rr_arb2 (
        .clk        (clk),
        .rst        (rst),
        .req_i      ({m1_req, m0_req}),
        .lock_i     (m1_lock),
        .grant_en_i (grantEn),
        .win_o      (win)
    );

    // bus_we defaults to zero so it is only nonzero in the ADDR cycle of a write.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        busAddr_d = busAddr_q;
        busQin_d  = busQin_q;
        busWe_d   = WE_READ;
        gnt_d     = '0;
        rvalid_d  = '0;
        rdata_d   = rdata_q;
        waitCnt_d = waitCnt_q;

        case (state_q)
            ST_IDLE: begin
                if (grantEn) begin
                    state_d   = ST_ADDR;
                    owner_d   = win;
                    busAddr_d = (win == MST_M1) ? m1_addr  : m0_addr;
                    busQin_d  = (win == MST_M1) ? m1_wdata : m0_wdata;
                    busWe_d   = (win == MST_M1) ? m1_we    : m0_we;
                    gnt_d     = (win == MST_M1) ? 2'b10 : 2'b01;
                end
            end
            ST_ADDR: begin
                if (busWe_q != WE_READ) begin
                    state_d = ST_IDLE;
                end else if (RD_LAT == 0) begin
                    rdata_d  = bus_qout;
                    rvalid_d = (owner_q == MST_M1) ? 2'b10 : 2'b01;
                    state_d  = ST_RDONE;
                end else begin
                    waitCnt_d = '0;
                    state_d   = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                if (waitCnt_q == LAST_WAIT) begin
                    rdata_d  = bus_qout;
                    rvalid_d = (owner_q == MST_M1) ? 2'b10 : 2'b01;
                    state_d  = ST_RDONE;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            ST_RDONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= MST_M0;
            busAddr_q <= '0;
            busQin_q  <= '0;
            busWe_q   <= WE_READ;
            gnt_q     <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
            waitCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            busAddr_q <= busAddr_d;
            busQin_q  <= busQin_d;
            busWe_q   <= busWe_d;
            gnt_q     <= gnt_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    assign m0_gnt    = gnt_q[0];
    assign m1_gnt    = gnt_q[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = rdata_q;
    assign m1_rdata  = rdata_q;
    assign bus_addr  = busAddr_q;
    assign bus_qin   = busQin_q;
    assign bus_we    = busWe_q;

endmodule

// File: tb/tb_localbus_arbiter.sv
// Scoreboard bench for localbus_arbiter: two master agents plus a transaction-level
// model that predicts every grant and read return from the arbitration rules.
module tb_localbus_arbiter;

    localparam int XLEN     = 32;
    localparam int RD_LAT   = 1;
    localparam int MAX_LOCK = 4;

    typedef struct {
        int          cyc;
        bit          m;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  we;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            m0_req = 1'b0, m1_req = 1'b0, m1_lock = 1'b0;
    logic [XLEN-1:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [2:0]      m0_we = '0, m1_we = '0;
    logic            m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [XLEN-1:0] m0_rdata, m1_rdata, bus_addr, bus_qin, bus_qout;
    logic [2:0]      bus_we;
    logic [XLEN-1:0] qoutReg = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t gntQ[$];
    exp_t rvQ[$];

    // Agent and model state
    bit          pend [2];
    logic [31:0] pAddr [2];
    logic [31:0] pData [2];
    logic [2:0]  pWe [2];
    bit          randomOn = 0;
    bit          lockRandom = 0;
    bit          lockVal = 0;
    int          issuePct = 0;
    int          dropPct = 0;
    bit          lastGnt = 1;
    int          lockCnt = 0;
    int          freeAt = 0;

    localbus_arbiter #(
        .XLEN     (XLEN),
        .RD_LAT   (RD_LAT),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_we     (m0_we),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_we     (m1_we),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .m1_lock   (m1_lock),
        .bus_addr  (bus_addr),
        .bus_qin   (bus_qin),
        .bus_we    (bus_we),
        .bus_qout  (bus_qout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Block-RAM style memory: data is a fixed function of the address, one cycle late.
    function automatic logic [31:0] memFn(input logic [31:0] a);
        return a ^ 32'h0234_5668;
    endfunction

    always @(posedge clk) qoutReg <= memFn(bus_addr);
    assign bus_qout = qoutReg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic newTxn(input int m);
        pend[m]  = 1;
        pAddr[m] = {4'h1, 26'($urandom), 2'b00};
        pData[m] = $urandom;
        case ($urandom_range(3))
            0, 1:    pWe[m] = 3'b000;
            2:       pWe[m] = 3'b100;
            default: pWe[m] = 3'($urandom_range(7, 1));
        endcase
    endtask

    task automatic applyStimulus();
        m0_req   = pend[0];
        m0_addr  = pAddr[0];
        m0_wdata = pData[0];
        m0_we    = pWe[0];
        m1_req   = pend[1];
        m1_addr  = pAddr[1];
        m1_wdata = pData[1];
        m1_we    = pWe[1];
        m1_lock  = lockVal;
    endtask

    // The bus is free again 2 cycles after a write decision and 3+RD_LAT after a read.
    task automatic runModel();
        exp_t e;
        bit   granted;
        bit   w;
        granted = 0;
        w = 0;
        if (!rst && cyc >= freeAt && (pend[0] || pend[1])) begin
            granted = 1;
            if (pend[0] && !pend[1])  w = 0;
            else if (!pend[0])        w = 1;
            else if (lockVal)         w = (lockCnt < MAX_LOCK);
            else                      w = !lastGnt;
            e.cyc  = cyc + 1;
            e.m    = w;
            e.addr = pAddr[w];
            e.data = pData[w];
            e.we   = pWe[w];
            gntQ.push_back(e);
            if (pWe[w] == 3'b000) begin
                e.cyc  = cyc + 2 + RD_LAT;
                e.data = memFn(pAddr[w]);
                rvQ.push_back(e);
                freeAt = cyc + 3 + RD_LAT;
            end else begin
                freeAt = cyc + 2;
            end
            lastGnt = w;
        end
        if (!lockVal)      lockCnt = 0;
        else if (granted)  lockCnt = w ? ((lockCnt < 255) ? lockCnt + 1 : 255) : 0;
    endtask

    task automatic stepCycle();
        logic [1:0] g;
        @(negedge clk);
        g = {m1_gnt, m0_gnt};
        for (int m = 0; m < 2; m++) begin
            if (g[m]) pend[m] = 0;
            if (randomOn) begin
                if (pend[m] && !g[m] && $urandom_range(99) < dropPct) pend[m] = 0;
                else if (!pend[m] && $urandom_range(99) < issuePct) newTxn(m);
            end
        end
        if (randomOn && lockRandom && $urandom_range(99) < 5) lockVal = ~lockVal;
        applyStimulus();
        runModel();
    endtask

    // Asserts reset from the current negedge; any predicted traffic is discarded.
    task automatic doReset(input int n);
        rst = 1'b1;
        pend[0] = 0;
        pend[1] = 0;
        lockVal = 0;
        applyStimulus();
        gntQ.delete();
        rvQ.delete();
        repeat (n) @(negedge clk);
        rst = 1'b0;
        lastGnt = 1;
        lockCnt = 0;
        freeAt  = cyc;
    endtask

    task automatic waitGrant(input int m);
        int n;
        n = 0;
        while (pend[m] && n < 30) begin
            stepCycle();
            n++;
        end
        check("grant_timeout", 32'(pend[m]), 32'd0);
    endtask

    task automatic drain();
        int n;
        randomOn = 0;
        n = 0;
        while ((pend[0] || pend[1]) && n < 60) begin
            stepCycle();
            n++;
        end
        check("drain_timeout", 32'({pend[1], pend[0]}), 32'd0);
        repeat (6) stepCycle();
    endtask

    task automatic checkOutput();
        exp_t e;
        if (gntQ.size() > 0 && gntQ[0].cyc <= cyc) begin
            e = gntQ.pop_front();
            check("gnt_cycle", 32'(cyc), 32'(e.cyc));
            check("gnt_vec", 32'({m1_gnt, m0_gnt}), e.m ? 32'd2 : 32'd1);
            check("bus_addr", bus_addr, e.addr);
            check("bus_qin", bus_qin, e.data);
            check("bus_we", 32'(bus_we), 32'(e.we));
        end else begin
            check("gnt_idle", 32'({m1_gnt, m0_gnt}), 32'd0);
            check("bus_we_idle", 32'(bus_we), 32'd0);
        end
        if (rvQ.size() > 0 && rvQ[0].cyc <= cyc) begin
            e = rvQ.pop_front();
            check("rvalid_cycle", 32'(cyc), 32'(e.cyc));
            check("rvalid_vec", 32'({m1_rvalid, m0_rvalid}), e.m ? 32'd2 : 32'd1);
            check("rdata", e.m ? m1_rdata : m0_rdata, e.data);
        end else begin
            check("rvalid_idle", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            checkOutput();
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        pend[0] = 0; pend[1] = 0;
        for (int m = 0; m < 2; m++) begin
            pAddr[m] = '0; pData[m] = '0; pWe[m] = '0;
        end

        doReset(3);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_qin", bus_qin, 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
        check("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        check("rst_m1_rdata", m1_rdata, 32'd0);

        $display("[TB] directed M0 write");
        pend[0] = 1; pAddr[0] = 32'h1000_0004; pData[0] = 32'hDEAD_BEEF; pWe[0] = 3'b100;
        waitGrant(0);
        repeat (3) stepCycle();

        $display("[TB] directed M1 read");
        pend[1] = 1; pAddr[1] = 32'h1000_0010; pData[1] = 32'h0; pWe[1] = 3'b000;
        waitGrant(1);
        repeat (5) stepCycle();

        $display("[TB] both masters requesting, no lock");
        randomOn = 1; issuePct = 100; dropPct = 0; lockVal = 0; lockRandom = 0;
        repeat (40) stepCycle();
        drain();

        $display("[TB] M1 burst lock");
        randomOn = 1; lockVal = 1;
        repeat (60) stepCycle();
        lockVal = 0;
        drain();

        $display("[TB] reset during read wait");
        pend[0] = 1; pAddr[0] = 32'h1000_0020; pData[0] = 32'h0; pWe[0] = 3'b000;
        waitGrant(0);
        stepCycle();
        doReset(1);
        check("midrst_bus_we", 32'(bus_we), 32'd0);
        check("midrst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        check("midrst_bus_addr", bus_addr, 32'd0);
        pend[0] = 1; pAddr[0] = 32'h1000_0030; pWe[0] = 3'b000;
        waitGrant(0);
        repeat (5) stepCycle();

        $display("[TB] M0 pulse while M1 read in flight");
        pend[1] = 1; pAddr[1] = 32'h1000_0040; pWe[1] = 3'b000;
        waitGrant(1);
        pend[0] = 1; pAddr[0] = 32'h2000_0000; pData[0] = 32'hCAFE_F00D; pWe[0] = 3'b111;
        stepCycle();
        pend[0] = 0;
        repeat (6) stepCycle();
        check("pulse_bus_addr", bus_addr, 32'h1000_0040);

        $display("[TB] randomized traffic");
        randomOn = 1; issuePct = 30; dropPct = 5; lockRandom = 1; lockVal = 0;
        repeat (1500) stepCycle();
        lockVal = 0;
        drain();

        check("gntQ_empty", 32'(gntQ.size()), 32'd0);
        check("rvQ_empty", 32'(rvQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
